seq_fourty_eight_bit_vedic_subtractor: RTL and testbench

- Multi-cycle 48-bit unsigned subtractor with borrow; the inverse companion to the team's chained 48-bit Vedic adder.
- Computes diff = in1 - in2 - bin over NCHUNK = WIDTH/CHUNK clock cycles, one CHUNK-bit slice per cycle from LSB upward.
- The borrow ripples between slices through a register.
- Valid/ready handshake on input and output, so it can sit in the approximate-arithmetic datapath alongside the adder chain.
- Optional approximate LSB region for accuracy/energy experiments.

---
 rtl/seq_fourty_eight_bit_vedic_subtractor_pkg.sv | 19 +
 rtl/seq_fourty_eight_bit_vedic_subtractor_chunk.sv | 44 ++++
 rtl/seq_fourty_eight_bit_vedic_subtractor.sv | 107 ++++++++++
 tb/tb_seq_fourty_eight_bit_vedic_subtractor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_fourty_eight_bit_vedic_subtractor_pkg.sv
// Shared definitions for the multi-cycle chunked subtractor.
package seq_fourty_eight_bit_vedic_subtractor_pkg;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  localparam int unsigned DefWidth = 48;
  localparam int unsigned DefChunk = 24;

  // Number of slices processed, one per cycle.
  function automatic int unsigned calc_nchunk(int unsigned width, int unsigned chunk);
    return width / chunk;
  endfunction

  // Slice index width; never narrower than one bit.
  function automatic int unsigned calc_idx_width(int unsigned nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/seq_fourty_eight_bit_vedic_subtractor_chunk.sv
// Combinational CHUNK-bit a - b - bin. When approx_en is set and APPROX_BITS > 0,
// the low APPROX_BITS bits become a XOR b, bin is ignored and no borrow enters bit
// APPROX_BITS; the upper bits stay exact.
module chunk_vedic_subtractor
  import seq_fourty_eight_bit_vedic_subtractor_pkg::*;
#(
  parameter int unsigned CHUNK       = DefChunk,
  parameter int unsigned APPROX_BITS = 0
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bin,
  input  logic             approx_en,
  output logic [CHUNK-1:0] diff,
  output logic             bout
);

  logic [CHUNK:0] exact_res;

  assign exact_res = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};

  if (APPROX_BITS > 0) begin : g_approx
    localparam int unsigned HiW = CHUNK - APPROX_BITS;
    logic [HiW:0] hi_res;

    assign hi_res = {1'b0, a[CHUNK-1:APPROX_BITS]} - {1'b0, b[CHUNK-1:APPROX_BITS]};

    // Pick approximate or exact slice result.
    always_comb begin
      diff = exact_res[CHUNK-1:0];
      bout = exact_res[CHUNK];
      if (approx_en) begin
        diff = {hi_res[HiW-1:0], a[APPROX_BITS-1:0] ^ b[APPROX_BITS-1:0]};
        bout = hi_res[HiW];
      end
    end
  end else begin : g_exact
    logic unused_approx_en;
    assign unused_approx_en = approx_en;
    assign diff = exact_res[CHUNK-1:0];
    assign bout = exact_res[CHUNK];
  end

endmodule

// File: rtl/seq_fourty_eight_bit_vedic_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: one CHUNK slice per cycle, LSB first, with the
// borrow carried between slices in a register. Valid/ready on both sides.
module seq_fourty_eight_bit_vedic_subtractor
  import seq_fourty_eight_bit_vedic_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH       = DefWidth,
  parameter int unsigned CHUNK       = DefChunk,
  parameter int unsigned APPROX_BITS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned NChunk   = calc_nchunk(WIDTH, CHUNK);
  localparam int unsigned IdxWidth = calc_idx_width(NChunk);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NChunk - 1);

  state_e              state_q;
  logic [WIDTH-1:0]    a_q, b_q, diff_q;
  logic                borrow_q, bout_q, in_ready_q, out_valid_q;
  logic [IdxWidth-1:0] idx_q;

  logic [31:0]         slice_shift;
  logic [CHUNK-1:0]    a_slice, b_slice, slice_diff;
  logic                slice_bout;

  assign slice_shift = 32'(idx_q) * CHUNK;
  assign a_slice     = CHUNK'(a_q >> slice_shift);
  assign b_slice     = CHUNK'(b_q >> slice_shift);

  chunk_vedic_subtractor #(
    .CHUNK       (CHUNK),
    .APPROX_BITS (APPROX_BITS)
  ) u_chunk (
    .a         (a_slice),
    .b         (b_slice),
    .bin       (borrow_q),
    .approx_en (idx_q == '0),
    .diff      (slice_diff),
    .bout      (slice_bout)
  );

  // Control FSM with registered handshake outputs and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      bout_q      <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q        <= in1;
            b_q        <= in2;
            borrow_q   <= bin;
            idx_q      <= '0;
            diff_q     <= '0;
            bout_q     <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= StCalc;
          end
        end
        StCalc: begin
          // diff was cleared on entry, so OR-ing each slice in acts as a write.
          diff_q   <= diff_q | (WIDTH'(slice_diff) << slice_shift);
          borrow_q <= slice_bout;
          if (idx_q == LastIdx) begin
            bout_q      <= slice_bout;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule

// File: tb/tb_seq_fourty_eight_bit_vedic_subtractor.sv
// Directed and randomised checks of the chunked subtractor against an arithmetic model.
module tb_seq_fourty_eight_bit_vedic_subtractor;

  typedef struct packed {
    logic [47:0] d;
    logic        b;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid0, in_valid1, in_ready0, in_ready1;
  logic        out_valid0, out_valid1, out_ready;
  logic [47:0] in1, in2, diff0, diff1;
  logic        bin, bout0, bout1;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_fourty_eight_bit_vedic_subtractor #(
    .WIDTH(48), .CHUNK(24), .APPROX_BITS(0)
  ) u_exact (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in1(in1), .in2(in2),
    .bin(bin), .out_valid(out_valid0), .out_ready(out_ready), .diff(diff0), .bout(bout0)
  );

  seq_fourty_eight_bit_vedic_subtractor #(
    .WIDTH(48), .CHUNK(24), .APPROX_BITS(8)
  ) u_approx (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in1(in1), .in2(in2),
    .bin(bin), .out_valid(out_valid1), .out_ready(out_ready), .diff(diff1), .bout(bout1)
  );

  function automatic res_t model_exact(logic [47:0] a, logic [47:0] b, logic c);
    res_t r;
    r.d = a - b - 48'(c);
    r.b = ({1'b0, a} < ({1'b0, b} + 49'(c)));
    return r;
  endfunction

  function automatic res_t model_approx(logic [47:0] a, logic [47:0] b);
    res_t r;
    r.d = {a[47:8] - b[47:8], a[7:0] ^ b[7:0]};
    r.b = (a[47:8] < b[47:8]);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard compare: every cycle a result is presented it must match the model.
  always @(negedge clk) begin
    if (!rst && out_valid0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 64'(out_valid0), 64'(0));
      end else begin
        check("model_diff", 64'(diff0), 64'(exp_q[0].d));
        check("model_bout", 64'(bout0), 64'(exp_q[0].b));
        check("ready_low_in_done", 64'(in_ready0), 64'(0));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [47:0] a, input logic [47:0] b, input logic c, input bit push);
    int n = 0;
    in1 = a; in2 = b; bin = c; in_valid0 = 1'b1;
    @(negedge clk);
    while (!in_ready0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready0) check("send_timeout", 64'(in_ready0), 64'(1));
    if (push) exp_q.push_back(model_exact(a, b, c));
    @(posedge clk); #1;
    in_valid0 = 1'b0;
  endtask

  task automatic wait_valid0();
    int n = 0;
    @(negedge clk);
    while (!out_valid0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid0) check("result_timeout", 64'(out_valid0), 64'(1));
  endtask

  task automatic expect_result(input string name, input logic [47:0] d, input logic b);
    out_ready = 1'b1;
    wait_valid0();
    check({name, "_diff"}, 64'(diff0), 64'(d));
    check({name, "_bout"}, 64'(bout0), 64'(b));
    @(posedge clk); #1;
  endtask

  task automatic get_result(input int stall);
    out_ready = (stall == 0);
    wait_valid0();
    repeat (stall) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_approx(input logic [47:0] a, input logic [47:0] b, input logic c,
                             input logic [47:0] d, input logic bo);
    int   n = 0;
    res_t m;
    m = model_approx(a, b);
    in1 = a; in2 = b; bin = c; in_valid1 = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("approx_in_ready", 64'(in_ready1), 64'(1));
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    @(negedge clk);
    while (!out_valid1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("approx_valid", 64'(out_valid1), 64'(1));
    check("approx_diff", 64'(diff1), 64'(d));
    check("approx_bout", 64'(bout1), 64'(bo));
    check("approx_model_diff", 64'(diff1), 64'(m.d));
    check("approx_model_bout", 64'(bout1), 64'(m.b));
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [47:0] a, b;
    logic        c;

    // Reset with in_valid asserted: reset must win.
    rst = 1'b1; in_valid0 = 1'b1; in_valid1 = 1'b0; out_ready = 1'b1;
    in1 = 48'h5; in2 = 48'h1; bin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready0), 64'(1));
    check("rst_out_valid", 64'(out_valid0), 64'(0));
    check("rst_diff", 64'(diff0), 64'(0));
    check("rst_bout", 64'(bout0), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0; in_valid0 = 1'b0;
    @(negedge clk);
    check("no_latch_in_rst", 64'(in_ready0), 64'(1));
    check("no_result_in_rst", 64'(out_valid0), 64'(0));
    @(posedge clk); #1;

    // Cross-chunk borrow and two-cycle latency.
    send(48'h000001000000, 48'h000000000001, 1'b0, 1'b1);
    @(negedge clk);
    check("lat_cycle0", 64'(out_valid0), 64'(0));
    @(negedge clk);
    check("lat_cycle1", 64'(out_valid0), 64'(0));
    @(negedge clk);
    check("lat_cycle2", 64'(out_valid0), 64'(1));
    check("xchunk_diff", 64'(diff0), 64'h000000FFFFFF);
    check("xchunk_bout", 64'(bout0), 64'(0));
    @(posedge clk); #1;

    // Underflow cases.
    send(48'h0, 48'h1, 1'b0, 1'b1);
    expect_result("uflow", 48'hFFFFFFFFFFFF, 1'b1);
    send(48'h123456789ABC, 48'h123456789ABC, 1'b1, 1'b1);
    expect_result("equal_bin", 48'hFFFFFFFFFFFF, 1'b1);

    // Backpressure; a new request waits until after the handshake.
    out_ready = 1'b0;
    send(48'h100, 48'h1, 1'b0, 1'b1);
    wait_valid0();
    @(posedge clk); #1;
    in1 = 48'h7; in2 = 48'h3; bin = 1'b0; in_valid0 = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", 64'(out_valid0), 64'(1));
      check("bp_in_ready", 64'(in_ready0), 64'(0));
      check("bp_diff", 64'(diff0), 64'h0000000000FF);
      check("bp_bout", 64'(bout0), 64'(0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 64'(in_ready0), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_idle_ready", 64'(in_ready0), 64'(1));
    check("bp_idle_valid", 64'(out_valid0), 64'(0));
    exp_q.push_back(model_exact(48'h7, 48'h3, 1'b0));
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    expect_result("bp_next", 48'h4, 1'b0);

    // Reset during CALC discards the pending result.
    send(48'hABC, 48'h1, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready0), 64'(1));
    check("midrst_out_valid", 64'(out_valid0), 64'(0));
    check("midrst_diff", 64'(diff0), 64'(0));
    @(posedge clk); #1;
    send(48'h5, 48'h3, 1'b0, 1'b1);
    expect_result("after_rst", 48'h2, 1'b0);

    // Approximate low byte.
    send_approx(48'h10, 48'h01, 1'b1, 48'h000000000011, 1'b0);
    send_approx(48'h000001000005, 48'h000000000107, 1'b1, 48'h000000FFFF02, 1'b0);

    // Random regression with stalls.
    for (int i = 0; i < 1500; i++) begin
      a = 48'({$urandom(), $urandom()});
      b = (i % 4 == 0) ? a : 48'({$urandom(), $urandom()});
      c = 1'($urandom_range(0, 1));
      send(a, b, c, 1'b1);
      get_result(int'($urandom_range(0, 3)));
    end

    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
